// File: rtl/mcse_gpio_pkg.sv
// Shared GPIO layout, frame constants and frame-FSM state type for the MCSE GPIO boot
// protocol; used by both the host-side responder and the MCSE-side receiver.
package mcse_gpio_pkg;

  localparam int GPIO_N    = 32;
  localparam int ID_W      = 256;
  localparam int WORD_W    = 16;
  localparam int IDX_W     = 4;
  localparam int NUM_WORDS = ID_W / WORD_W;

  localparam int RST_REQ    = 0;
  localparam int RST_ACK    = 1;
  localparam int REL_REQ    = 4;
  localparam int REL_ACK    = 5;
  localparam int WAKE       = 6;
  localparam int WAKE_ACK   = 7;
  localparam int IDX_LO     = 8;
  localparam int IDX_HI     = 11;
  localparam int IPID_TRIG  = 12;
  localparam int IPID_VALID = 13;
  localparam int DATA_LO    = 16;

  localparam logic [WORD_W-1:0] HDR_WORD = 16'h7A7A;
  localparam logic [WORD_W-1:0] TRL_WORD = 16'hB9B9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_TRL,
    ST_WAIT_LOW
  } frame_state_e;

endpackage

// File: rtl/ipid_frame_serializer.sv
// Streams one latched IP ID as a header / 16 payload words (MSB word first) / trailer
// burst, then holds off until the trigger level drops.
//
// state       | meaning
// ST_IDLE     | waiting for trigger level; latches the selected ID on start
// ST_HDR      | header word on the bus
// ST_PAY      | 16 payload words, counter tracks the word index
// ST_TRL      | trailer word on the bus; frame counted on exit
// ST_WAIT_LOW | bus quiet until the trigger is released
module ipid_frame_serializer
  import mcse_gpio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [ID_W-1:0]   id_sel,
  output logic              frame_start,
  output logic              frame_done,
  output logic              valid,
  output logic [WORD_W-1:0] word
);

  frame_state_e      state;
  logic [3:0]        cnt;
  logic [ID_W-1:0]   shreg;

  assign frame_start = (state == ST_IDLE) && trig;
  assign frame_done  = (state == ST_TRL);

  // Output registers are loaded with the word of the state being entered, so the
  // bus changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      valid <= 1'b0;
      word  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) begin
            state <= ST_HDR;
            shreg <= id_sel;
            cnt   <= '0;
            valid <= 1'b1;
            word  <= HDR_WORD;
          end
        end
        ST_HDR: begin
          state <= ST_PAY;
          word  <= shreg[ID_W-1 -: WORD_W];
          shreg <= {shreg[ID_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
        ST_PAY: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(NUM_WORDS - 1)) begin
            state <= ST_TRL;
            word  <= TRL_WORD;
          end else begin
            word  <= shreg[ID_W-1 -: WORD_W];
            shreg <= {shreg[ID_W-WORD_W-1:0], {WORD_W{1'b0}}};
          end
        end
        ST_TRL: begin
          state <= ST_WAIT_LOW;
          cnt   <= '0;
          valid <= 1'b0;
          word  <= '0;
        end
        ST_WAIT_LOW: begin
          if (!trig) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          word  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ipid_gpio_responder.sv
// Host-side responder to the MCSE GPIO requests: registered acknowledges plus the
// framed IP ID burst on gpio_in[31:16].
module ipid_gpio_responder
  import mcse_gpio_pkg::*;
#(
  parameter int NUM_IP = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GPIO_N-1:0]      mcse_gpio_out,
  input  logic [NUM_IP*ID_W-1:0] ipid_flat,
  input  logic                   reset_ack_en,
  input  logic                   release_ack_en,
  output logic [GPIO_N-1:0]      host_gpio_in,
  output logic                   frame_active,
  output logic [7:0]             frames_sent,
  output logic                   idx_err
);

  logic [IDX_W-1:0]  idx;
  logic              idx_oor;
  logic [ID_W-1:0]   id_sel;
  logic              frame_start;
  logic              frame_done;
  logic              valid;
  logic [WORD_W-1:0] word;
  logic              wake_ack;
  logic              rst_ack;
  logic              rel_ack;
  logic              unused_bits;

  assign idx     = mcse_gpio_out[IDX_HI:IDX_LO];
  assign idx_oor = int'(idx) >= NUM_IP;

  // An index with no backing ID selects all zeros rather than reading past the array.
  always_comb begin
    id_sel = '0;
    for (int i = 0; i < NUM_IP; i++) begin
      if (int'(idx) == i) id_sel = ipid_flat[i*ID_W +: ID_W];
    end
  end

  ipid_frame_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .trig        (mcse_gpio_out[IPID_TRIG]),
    .id_sel      (id_sel),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .valid       (valid),
    .word        (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wake_ack    <= 1'b0;
      rst_ack     <= 1'b0;
      rel_ack     <= 1'b0;
      frames_sent <= '0;
      idx_err     <= 1'b0;
    end else begin
      wake_ack <= mcse_gpio_out[WAKE];
      rst_ack  <= mcse_gpio_out[RST_REQ] & reset_ack_en;
      rel_ack  <= mcse_gpio_out[REL_REQ] & release_ack_en;
      idx_err  <= frame_start & idx_oor;
      if (frame_done) frames_sent <= frames_sent + 8'd1;
    end
  end

  always_comb begin
    host_gpio_in                        = '0;
    host_gpio_in[RST_ACK]               = rst_ack;
    host_gpio_in[REL_ACK]               = rel_ack;
    host_gpio_in[WAKE_ACK]              = wake_ack;
    host_gpio_in[IPID_VALID]            = valid;
    host_gpio_in[DATA_LO +: WORD_W]     = word;
  end

  assign frame_active = valid;

  assign unused_bits = ^{mcse_gpio_out[GPIO_N-1:IPID_TRIG+1], mcse_gpio_out[WAKE_ACK],
                         mcse_gpio_out[REL_ACK], mcse_gpio_out[3:1]};

endmodule

// File: tb/tb_ipid_gpio_responder.sv
// Bench for ipid_gpio_responder: two instances (16 and 8 IP IDs) checked every cycle
// against a queue-based frame model, plus directed literal checks.
module tb_ipid_gpio_responder;

  logic          clk;
  logic          rst;
  logic [31:0]   g;
  logic          rst_en;
  logic          rel_en;
  logic [4095:0] ipid;

  logic [31:0]   host_a, host_b;
  logic          act_a, act_b;
  logic [7:0]    fs_a, fs_b;
  logic          err_a, err_b;

  int n_cmp = 0;
  int n_err = 0;

  ipid_gpio_responder #(.NUM_IP(16)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .mcse_gpio_out  (g),
    .ipid_flat      (ipid),
    .reset_ack_en   (rst_en),
    .release_ack_en (rel_en),
    .host_gpio_in   (host_a),
    .frame_active   (act_a),
    .frames_sent    (fs_a),
    .idx_err        (err_a)
  );

  ipid_gpio_responder #(.NUM_IP(8)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .mcse_gpio_out  (g),
    .ipid_flat      (ipid[2047:0]),
    .reset_ack_en   (rst_en),
    .release_ack_en (rel_en),
    .host_gpio_in   (host_b),
    .frame_active   (act_b),
    .frames_sent    (fs_b),
    .idx_err        (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] q[$];
  logic        in_frame, waiting;
  logic        exp_v, exp_wk, exp_rs, exp_rl, exp_ea, exp_eb;
  logic [15:0] exp_wa, exp_wb;
  logic [7:0]  exp_fs;

  function automatic logic [255:0] id_of(input logic [3:0] idx, input int n_ip);
    if (int'(idx) >= n_ip) return '0;
    return ipid[int'(idx)*256 +: 256];
  endfunction

  function automatic logic [15:0] word_of(input logic [255:0] id, input int n);
    logic [255:0] s;
    s = id >> (240 - 16*n);
    return s[15:0];
  endfunction

  function automatic logic [31:0] mk(input logic [15:0] w, input logic v, input logic wk,
                                     input logic rl, input logic rs);
    return {w, 2'b00, v, 5'b00000, wk, 1'b0, rl, 3'b000, rs, 1'b0};
  endfunction

  task automatic m_reset();
    q.delete();
    in_frame = 0; waiting = 0;
    exp_v = 0; exp_wa = 0; exp_wb = 0; exp_fs = 0;
    exp_wk = 0; exp_rs = 0; exp_rl = 0; exp_ea = 0; exp_eb = 0;
  endtask

  task automatic m_step();
    logic          emit;
    logic [31:0]   p;
    logic [255:0]  ida, idb;
    logic [3:0]    idx;
    exp_wk = g[6];
    exp_rs = g[0] & rst_en;
    exp_rl = g[4] & rel_en;
    exp_v = 0; exp_wa = 0; exp_wb = 0; exp_ea = 0; exp_eb = 0;
    emit = 0;
    if (q.size() != 0) begin
      emit = 1;
    end else if (in_frame) begin
      in_frame = 0;
      exp_fs   = exp_fs + 8'd1;
      waiting  = 1;
    end else if (waiting) begin
      if (!g[12]) waiting = 0;
    end else if (g[12]) begin
      idx = g[11:8];
      ida = id_of(idx, 16);
      idb = id_of(idx, 8);
      q.push_back({16'h7A7A, 16'h7A7A});
      for (int n = 0; n < 16; n++) q.push_back({word_of(ida, n), word_of(idb, n)});
      q.push_back({16'hB9B9, 16'hB9B9});
      in_frame = 1;
      exp_ea = int'(idx) >= 16;
      exp_eb = int'(idx) >= 8;
      emit = 1;
    end
    if (emit) begin
      p = q.pop_front();
      exp_v = 1; exp_wa = p[31:16]; exp_wb = p[15:0];
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("gpio_a", host_a, mk(exp_wa, exp_v, exp_wk, exp_rl, exp_rs));
      check("gpio_b", host_b, mk(exp_wb, exp_v, exp_wk, exp_rl, exp_rs));
      check("active_a", 32'(act_a), 32'(exp_v));
      check("active_b", 32'(act_b), 32'(exp_v));
      check("frames_a", 32'(fs_a), 32'(exp_fs));
      check("frames_b", 32'(fs_b), 32'(exp_fs));
      check("idx_err_a", 32'(err_a), 32'(exp_ea));
      check("idx_err_b", 32'(err_b), 32'(exp_eb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic trig_on(input logic [3:0] idx);
    g[11:8] = idx;
    g[12]   = 1'b1;
  endtask

  initial begin
    rst = 1'b0; g = '0; rst_en = 0; rel_en = 0;
    for (int j = 0; j < 128; j++) ipid[j*32 +: 32] = $urandom;
    for (int k = 0; k < 16; k++) ipid[3*256 + 240 - 16*k +: 16] = 16'(k + 1);

    repeat (3) @(negedge clk);
    check("reset_gpio", host_a, 32'h0);
    check("reset_frames", 32'(fs_a), 32'h0);
    check("reset_active", 32'(act_a), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ID 3 frame with literal expectations
    trig_on(4'd3);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) check("id3_hdr", 32'(host_a[31:16]), 32'h7A7A);
      else if (i == 17) check("id3_trl", 32'(host_a[31:16]), 32'hB9B9);
      else check("id3_word", 32'(host_a[31:16]), 32'(i));
      check("id3_valid", 32'(host_a[13]), 32'h1);
    end
    g[12] = 1'b0;
    @(negedge clk);
    check("id3_valid_drop", 32'(host_a[13]), 32'h0);
    check("id3_frames", 32'(fs_a), 32'h1);
    repeat (2) @(negedge clk);

    // 16 back-to-back triggers, one per index
    for (int ip = 0; ip < 16; ip++) begin
      trig_on(4'(ip));
      repeat (18) @(negedge clk);
      g[12] = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("frames_after_16", 32'(fs_a), 32'd17);

    // acks during an active frame
    trig_on(4'd2);
    @(negedge clk); g[6] = 1'b1;
    @(negedge clk); check("wake_ack", 32'(host_a[7]), 32'h1);
    g[0] = 1'b1; rst_en = 0;
    @(negedge clk); check("rst_ack_gated", 32'(host_a[1]), 32'h0);
    rst_en = 1;
    @(negedge clk); check("rst_ack", 32'(host_a[1]), 32'h1);
    g[4] = 1'b1; rel_en = 0;
    @(negedge clk); check("rel_ack_gated", 32'(host_a[5]), 32'h0);
    rel_en = 1;
    @(negedge clk); check("rel_ack", 32'(host_a[5]), 32'h1);
    check("frame_during_acks", 32'(host_a[13]), 32'h1);
    g[6] = 1'b0;
    @(negedge clk); check("wake_ack_drop", 32'(host_a[7]), 32'h0);
    g[0] = 1'b0; g[4] = 1'b0;
    @(negedge clk); check("acks_drop", 32'({host_a[5], host_a[1]}), 32'h0);
    repeat (12) @(negedge clk);
    g[12] = 1'b0;
    repeat (3) @(negedge clk);

    // trigger dropped mid-payload, then re-raised as early as possible and held
    trig_on(4'd7);
    repeat (7) @(negedge clk);
    g[12] = 1'b0;
    repeat (13) @(negedge clk);
    trig_on(4'd9);
    repeat (45) @(negedge clk);
    check("hold_no_refire", 32'(act_a), 32'h0);
    g[12] = 1'b0;
    repeat (3) @(negedge clk);

    // index past the populated range on the 8-entry instance
    trig_on(4'd15);
    @(negedge clk);
    check("oor_err_b", 32'(err_b), 32'h1);
    check("oor_err_a", 32'(err_a), 32'h0);
    check("oor_hdr_b", 32'(host_b[31:16]), 32'h7A7A);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("oor_word_b", 32'(host_b[31:16]), 32'h0);
      if (i == 0) check("oor_err_once", 32'(err_b), 32'h0);
    end
    @(negedge clk);
    check("oor_trl_b", 32'(host_b[31:16]), 32'hB9B9);
    g[12] = 1'b0;
    repeat (3) @(negedge clk);

    // randomized traffic, with ID contents and index changing mid-frame
    begin
      logic t;
      t = 1'b0;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 9) == 0) t = ~t;
        g = $urandom;
        g[12] = t;
        rst_en = 1'($urandom);
        rel_en = 1'($urandom);
        if ($urandom_range(0, 3) == 0) ipid[$urandom_range(0, 127)*32 +: 32] = $urandom;
      end
      g = '0;
      repeat (25) @(negedge clk);
    end

    // asynchronous reset mid-payload with trigger held through release
    trig_on(4'd4);
    repeat (6) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_gpio_a", host_a, 32'h0);
    check("arst_gpio_b", host_b, 32'h0);
    check("arst_active", 32'(act_a), 32'h0);
    check("arst_frames", 32'(fs_a), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (18) @(negedge clk);
    check("post_rst_trl", 32'(host_a[31:16]), 32'hB9B9);
    g[12] = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_frames", 32'(fs_a), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
